// File: rtl/mini_aie_cgra_2x2.sv
// 2x2 coarse-grained array of 8-bit PEs driven by a one-command-per-cycle host port.
// Define MINI_AIE_SAT_EN to make ADD/SUB/MAC saturate instead of wrapping.
module mini_aie_cgra_2x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CFG  = 3'b001;
  localparam logic [2:0] OP_LDIN = 3'b010;
  localparam logic [2:0] OP_STEP = 3'b011;
  localparam logic [2:0] OP_LDK  = 3'b100;
  localparam logic [2:0] OP_SEL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RUN  = 3'b111;

  logic [7:0] cfg [4];
  logic [7:0] kst [4];
  logic [7:0] res [4];
  logic [7:0] res_nxt [4];
  logic [7:0] in_r;
  logic [1:0] sel;

  logic [2:0] opcode;
  logic [1:0] pe_idx;
  logic       unused_cmd_bits;

  assign opcode          = uio_in[7:5];
  assign pe_idx          = uio_in[1:0];
  assign unused_cmd_bits = ^uio_in[4:2];

  function automatic logic [7:0] pe_eval(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] r);
    logic [7:0] add_r, sub_r, mac_r;
`ifdef MINI_AIE_SAT_EN
    logic [8:0]  sum, dif;
    logic [15:0] prod;
    logic [16:0] mac;
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    prod  = {8'd0, a} * {8'd0, b};
    mac   = {9'd0, r} + {1'b0, prod};
    add_r = sum[8] ? 8'hFF : sum[7:0];
    sub_r = dif[8] ? 8'h00 : dif[7:0];
    mac_r = (|mac[16:8]) ? 8'hFF : mac[7:0];
`else
    add_r = a + b;
    sub_r = a - b;
    mac_r = r + a * b;
`endif
    case (op)
      4'd0:    pe_eval = a;
      4'd1:    pe_eval = add_r;
      4'd2:    pe_eval = sub_r;
      4'd3:    pe_eval = a * b;
      4'd4:    pe_eval = a & b;
      4'd5:    pe_eval = a | b;
      4'd6:    pe_eval = a ^ b;
      4'd7:    pe_eval = a << b[2:0];
      4'd8:    pe_eval = a >> b[2:0];
      4'd9:    pe_eval = mac_r;
      4'd10:   pe_eval = (a < b) ? a : b;
      4'd11:   pe_eval = (a > b) ? a : b;
      default: pe_eval = r;
    endcase
  endfunction

  // Every PE reads pre-edge results, so neighbour data moves one hop per step.
  for (genvar g = 0; g < 4; g++) begin : g_pe
    localparam logic [1:0] OWN = 2'(g);
    localparam logic [1:0] HN  = 2'(g ^ 1);
    localparam logic [1:0] VN  = 2'(g ^ 2);
    logic [7:0] opa, opb;

    always_comb begin
      opa = in_r;
      case (cfg[OWN][3:2])
        2'b00: opa = in_r;
        2'b01: opa = res[HN];
        2'b10: opa = res[VN];
        2'b11: opa = res[OWN];
      endcase
      opb = kst[OWN];
      case (cfg[OWN][1:0])
        2'b00: opb = kst[OWN];
        2'b01: opb = res[HN];
        2'b10: opb = res[VN];
        2'b11: opb = res[OWN];
      endcase
    end

    assign res_nxt[OWN] = pe_eval(cfg[OWN][7:4], opa, opb, res[OWN]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cfg[i] <= 8'h00;
        kst[i] <= 8'h00;
        res[i] <= 8'h00;
      end
      in_r <= 8'h00;
      sel  <= 2'd0;
    end else if (ena) begin
      case (opcode)
        OP_NOP:  ;
        OP_CFG:  cfg[pe_idx] <= ui_in;
        OP_LDIN: in_r <= ui_in;
        OP_LDK:  kst[pe_idx] <= ui_in;
        OP_SEL:  sel <= pe_idx;
        OP_CLR:  for (int i = 0; i < 4; i++) res[i] <= 8'h00;
        OP_STEP, OP_RUN: for (int i = 0; i < 4; i++) res[i] <= res_nxt[i];
        default: ;
      endcase
    end
  end

  assign uo_out  = res[sel];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_mini_aie_cgra_2x2.sv
// Directed self-checking bench for mini_aie_cgra_2x2; expectations follow MINI_AIE_SAT_EN.
module tb_mini_aie_cgra_2x2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [2:0] NOP = 3'd0, CFG = 3'd1, LDIN = 3'd2, STEP = 3'd3,
                         LDK = 3'd4, SEL = 3'd5, CLR = 3'd6, RUN = 3'd7;

`ifdef MINI_AIE_SAT_EN
  localparam logic [7:0] EXP_WRAP_ADD = 8'd255;
  localparam logic [7:0] EXP_WRAP_SUB = 8'd0;
`else
  localparam logic [7:0] EXP_WRAP_ADD = 8'd144;
  localparam logic [7:0] EXP_WRAP_SUB = 8'd255;
`endif

  mini_aie_cgra_2x2 dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one command on the falling edge, sample 1 ns after the rising edge.
  task automatic cmd(input logic [2:0] op, input logic [1:0] p, input logic [7:0] d);
    @(negedge clk);
    uio_in = {op, 3'b000, p};
    ui_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held;

    // Reset with a live STEP/CFG pattern on the pins; reset must win.
    ena    = 1'b1;
    uio_in = {STEP, 3'b101, 2'd3};
    ui_in  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_uo_out", uo_out, 8'd0);
    chk("reset_uio_out", uio_out, 8'd0);
    chk("reset_uio_oe", uio_oe, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    cmd(STEP, 2'd0, 8'h00);
    chk("default_step", uo_out, 8'd0);

    // Pipeline: PE0 passes IN, PE1 adds its horizontal neighbour and const.
    cmd(LDIN, 2'd0, 8'd5);
    cmd(CFG, 2'd0, 8'h00);
    cmd(CFG, 2'd1, 8'h14);
    cmd(LDK, 2'd1, 8'd3);
    cmd(SEL, 2'd1, 8'h00);
    chk("pipe_before_step", uo_out, 8'd0);
    cmd(STEP, 2'd0, 8'h00);
    chk("pipe_step1", uo_out, 8'd3);
    cmd(STEP, 2'd0, 8'h00);
    chk("pipe_step2", uo_out, 8'd8);
    cmd(SEL, 2'd0, 8'h00);
    chk("pipe_sel0", uo_out, 8'd5);

    // MAC on PE3: R + IN*const, starting from a cleared result.
    cmd(CFG, 2'd3, 8'h90);
    cmd(LDIN, 2'd0, 8'd3);
    cmd(LDK, 2'd3, 8'd4);
    cmd(SEL, 2'd3, 8'h00);
    chk("mac_sel3_prior", uo_out, 8'd5);
    cmd(CLR, 2'd0, 8'h00);
    chk("mac_clr0", uo_out, 8'd0);
    cmd(STEP, 2'd0, 8'h00);
    chk("mac_step1", uo_out, 8'd12);
    cmd(STEP, 2'd0, 8'h00);
    chk("mac_step2", uo_out, 8'd24);
    cmd(STEP, 2'd0, 8'h00);
    chk("mac_step3", uo_out, 8'd36);
    cmd(CLR, 2'd0, 8'h00);
    chk("mac_clr", uo_out, 8'd0);
    cmd(STEP, 2'd0, 8'h00);
    chk("mac_after_clr", uo_out, 8'd12);

    // Wrap/saturate on PE2: own result + const, then IN - const.
    cmd(CFG, 2'd2, 8'h1C);
    cmd(LDK, 2'd2, 8'd200);
    cmd(SEL, 2'd2, 8'h00);
    cmd(CLR, 2'd0, 8'h00);
    cmd(STEP, 2'd0, 8'h00);
    chk("add_200", uo_out, 8'd200);
    cmd(STEP, 2'd0, 8'h00);
    chk("add_overflow", uo_out, EXP_WRAP_ADD);
    cmd(CFG, 2'd2, 8'h20);
    cmd(LDIN, 2'd0, 8'd1);
    cmd(LDK, 2'd2, 8'd2);
    chk("cfg_not_same_edge", uo_out, EXP_WRAP_ADD);
    cmd(STEP, 2'd0, 8'h00);
    chk("sub_underflow", uo_out, EXP_WRAP_SUB);

    // ena=0: commands ignored, state holds.
    held = uo_out;
    @(negedge clk);
    ena = 1'b0;
    cmd(CFG, 2'd2, 8'h00);
    cmd(LDIN, 2'd0, 8'd7);
    cmd(STEP, 2'd0, 8'h00);
    chk("ena0_step_hold", uo_out, held);
    cmd(SEL, 2'd0, 8'h00);
    chk("ena0_sel_hold", uo_out, held);
    cmd(CLR, 2'd0, 8'h00);
    chk("ena0_clr_hold", uo_out, held);
    @(negedge clk);
    ena = 1'b1;
    cmd(LDIN, 2'd0, 8'd9);
    cmd(STEP, 2'd0, 8'h00);
    chk("ena1_step", uo_out, 8'd7);

    // RUN: PE3 accumulates const=1 every cycle the command is held.
    cmd(CFG, 2'd3, 8'h1C);
    cmd(LDK, 2'd3, 8'd1);
    cmd(SEL, 2'd3, 8'h00);
    cmd(CLR, 2'd0, 8'h00);
    @(negedge clk);
    uio_in = {RUN, 3'b000, 2'd0};
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("run_cycle%0d", i), uo_out, 8'(i));
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("run_reset", uo_out, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    cmd(NOP, 2'd0, 8'h00);
    chk("post_reset_hold", uo_out, 8'd0);
    // Config back to 0x00 means PE3 passes IN rather than accumulating.
    cmd(LDIN, 2'd0, 8'd6);
    cmd(SEL, 2'd3, 8'h00);
    cmd(STEP, 2'd0, 8'h00);
    chk("post_reset_cfg", uo_out, 8'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
